// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types, func3 codes and legality helpers for the load/store unit.
package rmrv_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic mis;
      case (f3)
         F3_H, F3_HU: mis = a[0];
         F3_W:        mis = (a != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Stores only have B/H/W; loads additionally have the unsigned BU/HU forms.
   function automatic logic is_illegal(input logic st, input logic [2:0] f3, input logic [1:0] a);
      logic bad;
      if (st) begin
         bad = (f3 >= 3'b011);
      end else begin
         bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      return bad || is_misaligned(f3, a);
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface lsu_mem_ctrl_if #(
   parameter int AW = 32
) ();
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic          mem_ack;
   logic [31:0]   mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Byte-lane steering: store enables/replication and load lane extract with extension.
module lsu_align
   import rmrv_lsu_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_word,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Store-side lane enables and data replication
   always_comb begin
      be        = 4'b0000;
      wdata_rep = 32'h0000_0000;
      case (func3)
         F3_B, F3_BU: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            be        = 4'b0011 << {lane[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
         end
         F3_W: begin
            be        = 4'b1111;
            wdata_rep = wdata;
         end
         default: begin
            be        = 4'b0000;
            wdata_rep = 32'h0000_0000;
         end
      endcase
   end

   // Load-side lane select and sign/zero extension
   always_comb begin
      byte_s = 8'h00;
      case (lane)
         2'b00:   byte_s = rdata_word[7:0];
         2'b01:   byte_s = rdata_word[15:8];
         2'b10:   byte_s = rdata_word[23:16];
         2'b11:   byte_s = rdata_word[31:24];
         default: byte_s = 8'h00;
      endcase
      if (lane[1]) begin
         half_s = rdata_word[31:16];
      end else begin
         half_s = rdata_word[15:0];
      end
      case (func3)
         F3_B:    ld_data = {{24{byte_s[7]}}, byte_s};
         F3_BU:   ld_data = {24'h00_0000, byte_s};
         F3_H:    ld_data = {{16{half_s[15]}}, half_s};
         F3_HU:   ld_data = {16'h0000, half_s};
         F3_W:    ld_data = rdata_word;
         default: ld_data = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: latches a core access, issues one memory request with byte
// enables, waits for a bounded-latency ack and returns extended data or a fault.
module lsu_mem_ctrl
   import rmrv_lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          we,
   input  logic [2:0]    func3,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic          stall,
   output logic          done,
   output logic [31:0]   rdata,
   output logic          fault,
   lsu_mem_ctrl_if.master mem
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   lsu_state_t    state_r, state_n;
   logic          we_r;
   logic [2:0]    func3_r;
   logic [AW-1:0] addr_r;
   logic [31:0]   wdata_r;
   logic [7:0]    cnt_r;
   logic [31:0]   rdata_r;
   logic          fault_r;
   logic          illegal_s;
   logic          in_req_s;
   logic [3:0]    be_s;
   logic [31:0]   wrep_s;
   logic [31:0]   ld_s;

   assign illegal_s = is_illegal(we, func3, addr[1:0]);

   lsu_align u_align (
      .func3      (func3_r),
      .lane       (addr_r[1:0]),
      .wdata      (wdata_r),
      .rdata_word (mem.mem_rdata),
      .be         (be_s),
      .wdata_rep  (wrep_s),
      .ld_data    (ld_s)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state: an ack in the final REQ cycle takes priority over the timeout
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_n = illegal_s ? DONE : REQ;
            end else begin
               state_n = IDLE;
            end
         end
         REQ: begin
            if (mem.mem_ack || (cnt_r == TO_LAST)) begin
               state_n = DONE;
            end else begin
               state_n = REQ;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Access latches, timeout counter and completion result
   always_ff @(posedge clk) begin
      if (reset) begin
         we_r    <= 1'b0;
         func3_r <= 3'b000;
         addr_r  <= {AW{1'b0}};
         wdata_r <= 32'h0000_0000;
         cnt_r   <= 8'd0;
         rdata_r <= 32'h0000_0000;
         fault_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  we_r    <= we;
                  func3_r <= func3;
                  addr_r  <= addr;
                  wdata_r <= wdata;
                  cnt_r   <= 8'd0;
                  rdata_r <= 32'h0000_0000;
                  fault_r <= illegal_s;
               end
            end
            REQ: begin
               cnt_r <= cnt_r + 8'd1;
               if (mem.mem_ack) begin
                  rdata_r <= we_r ? 32'h0000_0000 : ld_s;
                  fault_r <= 1'b0;
               end else if (cnt_r == TO_LAST) begin
                  rdata_r <= 32'h0000_0000;
                  fault_r <= 1'b1;
               end
            end
            DONE: begin
               rdata_r <= 32'h0000_0000;
               fault_r <= 1'b0;
            end
            default: begin
               rdata_r <= 32'h0000_0000;
               fault_r <= 1'b0;
            end
         endcase
      end
   end

   // Outputs decoded from state; bus fields are driven only while requesting
   always_comb begin
      in_req_s      = (state_r == REQ);
      stall         = !reset && ((start && (state_r == IDLE)) || in_req_s);
      done          = (state_r == DONE);
      rdata         = done ? rdata_r : 32'h0000_0000;
      fault         = done ? fault_r : 1'b0;
      mem.mem_req   = in_req_s;
      mem.mem_we    = in_req_s && we_r;
      mem.mem_addr  = in_req_s ? {addr_r[AW-1:2], 2'b00} : {AW{1'b0}};
      mem.mem_be    = in_req_s ? be_s : 4'b0000;
      mem.mem_wdata = in_req_s ? wrep_s : 32'h0000_0000;
   end

endmodule
